// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with a start/busy/done handshake and pipeline flush.
`timescale 1ns/1ps
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] port_a,
   input  logic [WIDTH-1:0] port_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] port_out,
   output logic             zero,
   output logic             negative
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
   state_t state, next_state;

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] prod, prod_step, prod_fix;
   logic [WIDTH-1:0]   operand, sel, result, special_res, mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic               is_div, hi_sel, neg, accept, special;
   logic               signed_a, signed_b, sign_a, sign_b;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return s ? ('0 - v) : v;
   endfunction

   // Operand signedness, magnitudes and the no-iteration special cases.
   always_comb begin
      signed_a    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
      signed_b    = op[2] ? ~op[0] : ~op[1];
      sign_a      = signed_a & port_a[WIDTH-1];
      sign_b      = signed_b & port_b[WIDTH-1];
      mag_a       = mag(port_a, sign_a);
      mag_b       = mag(port_b, sign_b);
      special     = 1'b0;
      special_res = '0;
      if (op[2] && (port_b == '0)) begin
         special     = 1'b1;
         special_res = op[1] ? port_a : '1;
      end else if (op[2] && !op[0] && (port_a == MIN_NEG) && (port_b == '1)) begin
         special     = 1'b1;
         special_res = op[1] ? '0 : MIN_NEG;
      end else begin
         special     = 1'b0;
         special_res = '0;
      end
   end

   // One iteration step, plus sign fixup used on the final step.
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
      div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, operand};
      if (!is_div) begin
         prod_step = {mul_sum, prod[WIDTH-1:1]};
      end else if (div_trial[WIDTH]) begin
         prod_step = {prod[2*WIDTH-2:0], 1'b0};
      end else begin
         prod_step = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      end
      // A high product word must be negated as a whole 2*WIDTH value.
      prod_fix = (neg && !is_div) ? ('0 - prod_step) : prod_step;
      sel      = hi_sel ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      result   = (neg && is_div) ? ('0 - sel) : sel;
   end

   // Next-state logic; DONE accepts a new request exactly like IDLE.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && !flush) begin
               accept     = 1'b1;
               next_state = special ? DONE : CALC;
            end else begin
               next_state = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               next_state = IDLE;
            end else if (count == LAST) begin
               next_state = DONE;
            end else begin
               next_state = CALC;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath registers and registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         port_out <= '0;
         count    <= '0;
         prod     <= '0;
         operand  <= '0;
         is_div   <= 1'b0;
         hi_sel   <= 1'b0;
         neg      <= 1'b0;
      end else begin
         busy <= (next_state == CALC);
         done <= (next_state == DONE);
         if (accept) begin
            is_div  <= op[2];
            hi_sel  <= op[2] ? op[1] : (op[1:0] != 2'b00);
            neg     <= (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
            operand <= op[2] ? mag_b : mag_a;
            prod    <= {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
            count   <= '0;
            if (special) begin
               port_out <= special_res;
            end
         end else if ((state == CALC) && !flush) begin
            prod  <= prod_step;
            count <= count + CW'(1);
            if (count == LAST) begin
               port_out <= result;
            end
         end
      end
   end

   assign zero     = (port_out == '0);
   assign negative = port_out[WIDTH-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a behavioural RV32M model,
// using a result scoreboard and exact done-latency checks.
`timescale 1ns/1ps
module tb_muldiv_unit;
   logic        CLK = 1'b0;
   logic        nRST, start, flush;
   logic [2:0]  op;
   logic [31:0] port_a, port_b, port_out;
   logic        busy, done, zero, negative;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prev;

   muldiv_unit #(.WIDTH(32)) dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op), .port_a(port_a), .port_b(port_b),
      .flush(flush), .busy(busy), .done(done), .port_out(port_out), .zero(zero),
      .negative(negative)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (!o[2]) return 1'b0;
      if (b == 32'h0) return 1'b1;
      return (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] as, bs, p;
      logic [63:0] up;
      as = {{32{a[31]}}, a};
      bs = {{32{b[31]}}, b};
      case (o)
         3'd0: begin p = as * bs; return p[31:0]; end
         3'd1: begin p = as * bs; return p[63:32]; end
         3'd2: begin p = as * $signed({32'h0, b}); return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   // Issue one operation; optional ignored start at CALC cycle ign_cyc.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int ign_cyc);
      int lat, busy_cnt;
      logic seen;
      logic [31:0] exp;
      lat = is_special(o, a, b) ? 1 : 33;
      exp_q.push_back(ref_result(o, a, b));
      @(negedge CLK);
      start = 1'b1; op = o; port_a = a; port_b = b;
      @(posedge CLK); #1;
      start = 1'b0; port_a = ~a; port_b = a ^ b ^ 32'h5A5A_5A5A;
      busy_cnt = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         if (k == ign_cyc) begin
            start = 1'b1; op = 3'd0; port_a = 32'h3; port_b = 32'h3;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            exp = exp_q.pop_front();
            chk({tag, " latency"}, 32'(k), 32'(lat));
            chk({tag, " result"}, port_out, exp);
            chk({tag, " busy cycles"}, 32'(busy_cnt), (lat == 1) ? 32'd0 : 32'd32);
         end else begin
            if (busy) busy_cnt++;
            @(posedge CLK); #1;
         end
      end
      if (!seen) begin
         chk({tag, " timeout"}, 32'd0, 32'd1);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic no_done(input string tag, input int n);
      int cnt = 0;
      for (int k = 0; k < n; k++) begin
         if (done) cnt++;
         @(posedge CLK); #1;
      end
      chk({tag, " no done"}, 32'(cnt), 32'd0);
   endtask

   initial begin
      nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; port_a = 32'h0; port_b = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset busy", {31'h0, busy}, 32'd0);
      chk("reset done", {31'h0, done}, 32'd0);
      chk("reset port_out", port_out, 32'h0);
      chk("reset zero", {31'h0, zero}, 32'd1);
      nRST = 1'b1;

      run_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      chk("MUL value", port_out, 32'hFFFF_FFEB);
      chk("MUL negative", {31'h0, negative}, 32'd1);
      run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("MULHU value", port_out, 32'hFFFF_FFFE);
      run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("MULH zero", {31'h0, zero}, 32'd1);
      run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      chk("MULHSU value", port_out, 32'hFFFF_FFFF);
      run_op("DIV", 3'd4, 32'hFFFF_FFEC, 32'd3, 0);
      chk("DIV value", port_out, 32'hFFFF_FFFA);
      run_op("REM", 3'd6, 32'hFFFF_FFEC, 32'd3, 0);
      chk("REM value", port_out, 32'hFFFF_FFFE);
      run_op("DIVU", 3'd5, 32'd100, 32'd7, 0);
      chk("DIVU value", port_out, 32'd14);
      run_op("REMU", 3'd7, 32'd100, 32'd7, 0);
      chk("REMU value", port_out, 32'd2);

      run_op("DIVU by zero", 3'd5, 32'd5, 32'd0, 0);
      chk("DIVU by zero value", port_out, 32'hFFFF_FFFF);
      run_op("REM by zero", 3'd6, 32'd5, 32'd0, 0);
      chk("REM by zero value", port_out, 32'd5);
      run_op("DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("DIV overflow value", port_out, 32'h8000_0000);
      run_op("REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("REM overflow zero", {31'h0, zero}, 32'd1);

      run_op("ignored start", 3'd5, 32'd100, 32'd7, 10);
      chk("ignored start value", port_out, 32'd14);

      for (int i = 0; i < 6; i++) begin
         logic [2:0] ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i == 2) ? 32'h0 : $urandom;
         run_op("random", ro, ra, rb, 0);
      end

      // Flush during CALC cycle 5: result discarded, port_out held.
      @(posedge CLK); #1;
      prev = port_out;
      @(negedge CLK);
      start = 1'b1; op = 3'd0; port_a = 32'd5; port_b = 32'd6;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("flush busy before", {31'h0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      chk("flush busy after", {31'h0, busy}, 32'd0);
      no_done("flush", 40);
      chk("flush port_out held", port_out, prev);

      // start together with flush is not accepted.
      @(negedge CLK);
      start = 1'b1; flush = 1'b1; op = 3'd5; port_a = 32'd9; port_b = 32'd3;
      @(posedge CLK); #1;
      start = 1'b0; flush = 1'b0;
      chk("start+flush busy", {31'h0, busy}, 32'd0);
      no_done("start+flush", 40);

      // Reset at CALC cycle 12.
      @(negedge CLK);
      start = 1'b1; op = 3'd3; port_a = 32'hFFFF_FFFF; port_b = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (11) @(posedge CLK);
      #1;
      chk("reset mid busy before", {31'h0, busy}, 32'd1);
      nRST = 1'b0;
      @(posedge CLK); #1;
      chk("reset mid busy", {31'h0, busy}, 32'd0);
      chk("reset mid done", {31'h0, done}, 32'd0);
      chk("reset mid port_out", port_out, 32'h0);
      chk("reset mid zero", {31'h0, zero}, 32'd1);
      nRST = 1'b1;
      no_done("reset mid", 40);

      // Back-to-back: second start issued in the DONE cycle of the first.
      run_op("b2b first", 3'd0, 32'd12345, 32'd678, 0);
      chk("b2b in DONE", {31'h0, done}, 32'd1);
      run_op("b2b second", 3'd7, 32'd1000, 32'd33, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
